// File: rtl/line_mem_adapter_if.sv
// Cache-side line port of line_mem_adapter: one 128-bit line request/response channel.
// The cache drives the master side; the adapter implements the slave side.
interface line_mem_adapter_if;
  logic         mem_r;
  logic         mem_w;
  logic [31:0]  mem_addr;
  logic [127:0] mem_w_data;
  logic [127:0] mem_r_data;
  logic         mem_ready;
  logic         busy;

  modport master (
    output mem_r, mem_w, mem_addr, mem_w_data,
    input  mem_r_data, mem_ready, busy
  );

  modport slave (
    input  mem_r, mem_w, mem_addr, mem_w_data,
    output mem_r_data, mem_ready, busy
  );
endinterface

// File: rtl/line_mem_adapter.sv
// Splits 128-bit cache line reads/writes into four 32-bit beats on a synchronous word RAM,
// with a fixed number of wait states ahead of each transaction and a one-cycle ready pulse.
module line_mem_adapter #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  line_mem_adapter_if.slave     bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [7:0] WAIT_LAST = HAS_WAIT ? 8'(WAIT_CYCLES - 1) : 8'd0;

  state_t                  state_r, state_s;
  logic [7:0]              cnt_r, cnt_s;
  logic                    op_wr_r, op_wr_s;
  logic [ADDR_WIDTH-3:0]   line_r, line_s;
  logic [3:0][31:0]        wbuf_r, wbuf_s;
  logic [3:0][31:0]        rbuf_r;
  logic [1:0]              cap_idx_s;

  logic [ADDR_WIDTH-1:0]   ram_addr_r, ram_addr_s;
  logic                    ram_we_r, ram_we_s;
  logic [31:0]             ram_wdata_r, ram_wdata_s;
  logic                    mem_ready_r, mem_ready_s;
  logic                    busy_r, busy_s;

  // Next-state logic; outputs are precomputed from the next state so they can be registered.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    op_wr_s = op_wr_r;
    line_s  = line_r;
    wbuf_s  = wbuf_r;
    case (state_r)
      S_IDLE: begin
        if (bus.mem_w || bus.mem_r) begin
          op_wr_s = bus.mem_w;
          line_s  = bus.mem_addr[ADDR_WIDTH+1:4];
          wbuf_s  = bus.mem_w_data;
          cnt_s   = 8'd0;
          if (HAS_WAIT) begin
            state_s = S_WAIT;
          end else if (bus.mem_w) begin
            state_s = S_WR;
          end else begin
            state_s = S_RD;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r >= WAIT_LAST) begin
          cnt_s   = 8'd0;
          state_s = op_wr_r ? S_WR : S_RD;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      S_RD: begin
        // Extra fifth cycle collects the data for the address issued at beat 3.
        if (cnt_r == 8'd4) begin
          cnt_s   = 8'd0;
          state_s = S_RESP;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      S_WR: begin
        if (cnt_r == 8'd3) begin
          cnt_s   = 8'd0;
          state_s = S_RESP;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      S_RESP: begin
        cnt_s   = 8'd0;
        state_s = S_IDLE;
      end
      default: begin
        cnt_s   = 8'd0;
        state_s = S_IDLE;
      end
    endcase

    ram_we_s    = (state_s == S_WR);
    mem_ready_s = (state_s == S_RESP);
    busy_s      = (state_s != S_IDLE);
    if ((state_s == S_WR) || ((state_s == S_RD) && (cnt_s < 8'd4))) begin
      ram_addr_s = {line_s, cnt_s[1:0]};
    end else begin
      ram_addr_s = ram_addr_r;
    end
    if (state_s == S_WR) begin
      ram_wdata_s = wbuf_s[cnt_s[1:0]];
    end else begin
      ram_wdata_s = ram_wdata_r;
    end
    cap_idx_s = cnt_r[1:0] - 2'd1;
  end

  // Control state, latched request and registered RAM/cache outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= S_IDLE;
      cnt_r       <= 8'd0;
      op_wr_r     <= 1'b0;
      line_r      <= '0;
      wbuf_r      <= '0;
      ram_addr_r  <= '0;
      ram_we_r    <= 1'b0;
      ram_wdata_r <= 32'd0;
      mem_ready_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      op_wr_r     <= op_wr_s;
      line_r      <= line_s;
      wbuf_r      <= wbuf_s;
      ram_addr_r  <= ram_addr_s;
      ram_we_r    <= ram_we_s;
      ram_wdata_r <= ram_wdata_s;
      mem_ready_r <= mem_ready_s;
      busy_r      <= busy_s;
    end
  end

  // Read line buffer: beat c captures the word addressed in beat c-1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rbuf_r <= '0;
    end else if ((state_r == S_RD) && (cnt_r != 8'd0)) begin
      rbuf_r[cap_idx_s] <= ram_rdata;
    end else begin
      rbuf_r <= rbuf_r;
    end
  end

  assign ram_addr       = ram_addr_r;
  assign ram_we         = ram_we_r;
  assign ram_wdata      = ram_wdata_r;
  assign bus.mem_ready  = mem_ready_r;
  assign bus.busy       = busy_r;
  assign bus.mem_r_data = rbuf_r;

endmodule

// File: tb/tb_line_mem_adapter.sv
// Randomized bench for line_mem_adapter: two instances (2 and 0 wait states), each on its own
// RAM model, checked against a transaction-level memory image and timing rules.
module tb_line_mem_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  line_mem_adapter_if bus0 ();
  line_mem_adapter_if bus1 ();

  logic [11:0] ram_addr0, ram_addr1;
  logic        ram_we0, ram_we1;
  logic [31:0] ram_wdata0, ram_wdata1, ram_rdata0, ram_rdata1;

  logic        pre_we;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;

  line_mem_adapter #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rstn(rstn), .bus(bus0),
    .ram_addr(ram_addr0), .ram_we(ram_we0), .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0)
  );

  line_mem_adapter #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rstn(rstn), .bus(bus1),
    .ram_addr(ram_addr1), .ram_we(ram_we1), .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
  );

  // Synchronous-read RAMs with a backdoor preload port.
  logic [31:0] mem0 [4096];
  logic [31:0] mem1 [4096];
  always @(posedge clk) begin
    if (pre_we) mem0[pre_addr] <= pre_data;
    else if (ram_we0) mem0[ram_addr0] <= ram_wdata0;
    ram_rdata0 <= mem0[ram_addr0];
  end
  always @(posedge clk) begin
    if (pre_we) mem1[pre_addr] <= pre_data;
    else if (ram_we1) mem1[ram_addr1] <= ram_wdata1;
    ram_rdata1 <= mem1[ram_addr1];
  end

  int rdy_cnt0 = 0;
  int rdy_cnt1 = 0;
  always @(posedge clk) begin
    if (bus0.mem_ready === 1'b1) rdy_cnt0 <= rdy_cnt0 + 1;
    if (bus1.mem_ready === 1'b1) rdy_cnt1 <= rdy_cnt1 + 1;
  end

  // Reference model: memory image, last read line and expected pulse count per instance.
  logic [31:0]  refmem [2][4096];
  logic [127:0] last_line [2];
  int           exp_rdy [2];
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int s, input logic r, input logic w,
                         input logic [31:0] a, input logic [127:0] d);
    if (s == 0) begin
      bus0.mem_r = r; bus0.mem_w = w; bus0.mem_addr = a; bus0.mem_w_data = d;
    end else begin
      bus1.mem_r = r; bus1.mem_w = w; bus1.mem_addr = a; bus1.mem_w_data = d;
    end
  endtask

  function automatic logic get_ready(input int s);
    return (s == 0) ? bus0.mem_ready : bus1.mem_ready;
  endfunction
  function automatic logic get_busy(input int s);
    return (s == 0) ? bus0.busy : bus1.busy;
  endfunction
  function automatic logic get_we(input int s);
    return (s == 0) ? ram_we0 : ram_we1;
  endfunction
  function automatic logic [11:0] get_addr(input int s);
    return (s == 0) ? ram_addr0 : ram_addr1;
  endfunction
  function automatic logic [31:0] get_wdata(input int s);
    return (s == 0) ? ram_wdata0 : ram_wdata1;
  endfunction
  function automatic logic [127:0] get_rdata(input int s);
    return (s == 0) ? bus0.mem_r_data : bus1.mem_r_data;
  endfunction

  function automatic int unsigned line_base(input logic [31:0] a);
    return ((int'(a >> 4)) % 1024) * 4;
  endfunction

  // One cache transaction, raised in an IDLE cycle; returns in the IDLE cycle after RESP.
  task automatic txn(input int s, input logic r, input logic w,
                     input logic [31:0] a, input logic [127:0] d);
    int          wc    = (s == 0) ? 2 : 0;
    int unsigned base  = line_base(a);
    int          lat   = wc + (w ? 5 : 6);
    int          n     = 0;
    int          beats = 0;
    int          first = -1;
    int          last  = -1;
    bit          got   = 1'b0;
    logic [127:0] exp_line;
    set_req(s, r, w, a, d);
    while (!got && n < 300) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == 1) chk("busy_rise", get_busy(s), 1'b1);
      if (get_we(s) === 1'b1) begin
        if (beats < 4) begin
          chk("beat_addr", get_addr(s), base + beats);
          chk("beat_data", get_wdata(s), d[32*beats +: 32]);
        end
        if (first < 0) first = n;
        last = n;
        beats++;
      end
      if (get_ready(s) === 1'b1) got = 1'b1;
    end
    set_req(s, 1'b0, 1'b0, 32'd0, 128'd0);
    if (!got) chk("ready_timeout", 1'b0, 1'b1);
    chk("latency", n, lat);
    chk("we_beats", beats, w ? 4 : 0);
    if (w) begin
      chk("first_beat", first, wc + 1);
      chk("last_beat", last, wc + 4);
      for (int k = 0; k < 4; k++) refmem[s][base + k] = d[32*k +: 32];
      chk("rdata_hold", get_rdata(s), last_line[s]);
    end else begin
      for (int k = 0; k < 4; k++) exp_line[32*k +: 32] = refmem[s][base + k];
      chk("rdata", get_rdata(s), exp_line);
      last_line[s] = exp_line;
    end
    exp_rdy[s]++;
    @(posedge clk);
    @(negedge clk);
    chk("ready_pulse", get_ready(s), 1'b0);
    chk("busy_fall", get_busy(s), 1'b0);
  endtask

  task automatic chk_reset_vals(input int s);
    chk("rst_ready", get_ready(s), 1'b0);
    chk("rst_busy", get_busy(s), 1'b0);
    chk("rst_we", get_we(s), 1'b0);
    chk("rst_addr", get_addr(s), 12'd0);
    chk("rst_wdata", get_wdata(s), 32'd0);
    chk("rst_rdata", get_rdata(s), 128'd0);
  endtask

  initial begin
    logic [127:0] d;
    logic [31:0]  a;
    logic [31:0]  old_w2, old_w3;
    int unsigned  b;
    bit           no_rdy;
    rstn = 1'b0;
    pre_we = 1'b0; pre_addr = 12'd0; pre_data = 32'd0;
    set_req(0, 1'b0, 1'b0, 32'd0, 128'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 128'd0);
    for (int i = 0; i < 2; i++) begin
      last_line[i] = 128'd0;
      exp_rdy[i]   = 0;
    end
    for (int i = 0; i < 4096; i++) refmem[0][i] = $urandom;
    refmem[0][12'h040] = 32'h11111111;
    refmem[0][12'h041] = 32'h22222222;
    refmem[0][12'h042] = 32'h33333333;
    refmem[0][12'h043] = 32'h44444444;
    for (int i = 0; i < 4096; i++) begin
      refmem[1][i] = refmem[0][i];
      @(negedge clk);
      pre_we = 1'b1; pre_addr = 12'(i); pre_data = refmem[0][i];
    end
    @(negedge clk);
    pre_we = 1'b0;
    @(negedge clk);
    chk_reset_vals(0);
    chk_reset_vals(1);
    rstn = 1'b1;
    @(negedge clk);
    chk_reset_vals(0);

    // Directed: preloaded read, write + readback, dirty miss, simultaneous request.
    txn(0, 1'b1, 1'b0, 32'h0000_0100, 128'd0);
    chk("read_0x100", bus0.mem_r_data, 128'h44444444_33333333_22222222_11111111);
    d = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    txn(0, 1'b0, 1'b1, 32'h0000_020C, d);
    txn(0, 1'b1, 1'b0, 32'h0000_0200, 128'd0);
    chk("readback_0x200", bus0.mem_r_data, d);
    txn(0, 1'b0, 1'b1, 32'h0000_0100, {$urandom, $urandom, $urandom, $urandom});
    txn(0, 1'b1, 1'b0, 32'h0000_0300, 128'd0);
    txn(0, 1'b1, 1'b1, 32'h0000_0400, {$urandom, $urandom, $urandom, $urandom});

    // Zero wait states and upper-address aliasing.
    d = {$urandom, $urandom, $urandom, $urandom};
    txn(1, 1'b0, 1'b1, 32'hFFFF_0010, d);
    txn(1, 1'b1, 1'b0, 32'h0000_0010, 128'd0);
    chk("alias_line", bus1.mem_r_data, d);
    txn(1, 1'b1, 1'b1, 32'h0000_0020, {$urandom, $urandom, $urandom, $urandom});

    // Randomized traffic over a small set of lines so reads revisit written data.
    for (int i = 0; i < 80; i++) begin
      int op;
      op = $urandom_range(0, 2);
      a  = ($urandom & 32'hFFFF_C00F) | (32'($urandom_range(0, 31)) << 4);
      d  = {$urandom, $urandom, $urandom, $urandom};
      txn(i % 2, (op != 1), (op != 0), a, d);
    end

    // Reset while write beat 2 is on the RAM port of the 2-wait-state instance.
    a = 32'h0000_0A50;
    b = line_base(a);
    old_w2 = refmem[0][b + 2];
    old_w3 = refmem[0][b + 3];
    d = {$urandom, $urandom, $urandom, $urandom};
    set_req(0, 1'b0, 1'b1, a, d);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("beat2_present", ram_we0, 1'b1);
    chk("beat2_addr", ram_addr0, b + 2);
    rstn = 1'b0;
    #1;
    chk_reset_vals(0);
    chk_reset_vals(1);
    set_req(0, 1'b0, 1'b0, 32'd0, 128'd0);
    last_line[0] = 128'd0;
    last_line[1] = 128'd0;
    @(negedge clk);
    rstn = 1'b1;
    no_rdy = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus0.mem_ready !== 1'b0 || bus0.busy !== 1'b0) no_rdy = 1'b0;
    end
    chk("no_ready_after_rst", no_rdy, 1'b1);
    chk("partial_w0", mem0[b], d[31:0]);
    chk("partial_w1", mem0[b + 1], d[63:32]);
    chk("partial_w2", (mem0[b + 2] == old_w2) || (mem0[b + 2] == d[95:64]), 1'b1);
    chk("partial_w3", mem0[b + 3], old_w3);
    refmem[0][b]     = d[31:0];
    refmem[0][b + 1] = d[63:32];
    refmem[0][b + 2] = mem0[b + 2];

    txn(0, 1'b1, 1'b0, a, 128'd0);
    txn(0, 1'b0, 1'b1, a, {$urandom, $urandom, $urandom, $urandom});
    txn(0, 1'b1, 1'b0, a, 128'd0);
    txn(1, 1'b1, 1'b0, 32'h0000_0010, 128'd0);

    @(negedge clk);
    chk("ready_count0", rdy_cnt0, exp_rdy[0]);
    chk("ready_count1", rdy_cnt1, exp_rdy[1]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
